imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate output width; the only legal values are 32 and 64.
REQ-002 The block SHALL have parameter TAG_W, default 5, giving the width of a sideband tag carried unmodified with each immediate.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream has an instruction.
REQ-006 in_ready  output  1  block can accept; driven from a register only.
REQ-007 in_instr  input  32  raw RV32 instruction word.
REQ-008 in_extop  input  3  immediate format select.
REQ-009 in_tag  input  TAG_W  sideband tag.
REQ-010 out_valid  output  1  out_imm, out_tag and out_err are valid.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 out_imm  output  XLEN  generated immediate.
REQ-013 out_tag  output  TAG_W  tag of the same transaction.
REQ-014 out_err  output  1  in_extop was illegal for this transaction.

Function
REQ-015 in_extop encoding SHALL be:
- 0 I: sext(instr[31:20])
- 1 U: sext({instr[31:12],12'b0})
- 2 S: sext({instr[31:25],instr[11:7]})
- 3 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
- 4 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
- 5 Z (CSR zimm): zext(instr[19:15])
- 6 SHAMT: zext(instr[25:20]) when XLEN=64, zext(instr[24:20]) when XLEN=32
REQ-016 In REQ-015, sext SHALL mean sign-extension of the MSB to XLEN bits, and zext SHALL mean zero-extension to XLEN bits.
REQ-017 in_extop=7 SHALL produce out_imm=0 and out_err=1; every other code SHALL produce out_err=0.
REQ-018 An input transfer SHALL occur on a cycle with in_valid&in_ready=1, and an output transfer SHALL occur on a cycle with out_valid&out_ready=1.
REQ-019 in_valid, in_instr, in_extop and in_tag SHALL be ignored when in_ready=0.
REQ-020 The immediate SHALL be computed from the input and captured at the input transfer, so out_valid rises one cycle after the transfer when the output stage is empty (latency 1).
REQ-021 The block SHALL be a 2-entry skid buffer (main + skid register), with state EMPTY, ONE or FULL.
REQ-022 The buffer SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-023 State transitions SHALL be:
- EMPTY, input transfer -> ONE; main loads.
- ONE, input transfer and no output transfer -> FULL; skid loads.
- ONE, input transfer and output transfer -> ONE; main loads the new entry.
- ONE, output transfer only -> EMPTY.
- FULL, output transfer -> ONE; main <= skid.
- All other cases SHALL hold state.
REQ-024 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL.
REQ-025 out_valid SHALL be 1 in ONE and FULL.
REQ-026 While out_valid=1 and out_ready=0, out_imm, out_tag and out_err SHALL remain stable.
REQ-027 Transactions SHALL leave the block in acceptance order, with no loss or duplication.
REQ-028 out_imm, out_tag and out_err SHALL come from the main register only, with no combinational path from in_* to out_*.
REQ-029 There SHALL be no combinational path from out_ready to in_ready.

Reset
REQ-030 While rst_n=0, the block SHALL be in EMPTY with out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_err=0, and the skid register cleared.
REQ-031 Assertion of rst_n=0 mid-operation, including in FULL, SHALL discard all held transactions immediately, without waiting for a clock edge.
REQ-032 The first input transfer SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-033 I-type, XLEN=32: in_instr=0xFFF00093, in_extop=0, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_err=0.
REQ-034 B-type: in_instr=0xFE000EE3, in_extop=3 -> out_imm=0xFFFFFFFC.
REQ-035 U-type, XLEN=64: in_instr=0x800000B7, in_extop=1 -> out_imm=0xFFFFFFFF80000000.
REQ-036 Backpressure: out_ready=0; send tags 1, 2, 3 back to back -> tags 1 and 2 accepted, in_ready=0 while tag 3 is held; out_ready=1 -> outputs tag 1, 2, 3 in order on consecutive cycles, with outputs stable while stalled.
REQ-037 Illegal code: in_extop=7 with any in_instr -> out_imm=0, out_err=1, and the tag is passed through.
REQ-038 Reset in FULL: drive rst_n=0 between clock edges -> out_valid=0 and in_ready=1 immediately; after release, the next transaction emerges with latency 1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator behind a two-entry skid buffer (main + skid register).
// Immediates are decoded at the input transfer; outputs come only from the main register.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_extop,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a cycle where valid and ready are both 1;
    // in_ready and out_valid are register outputs, so neither depends on the
    // same-cycle value of any input.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_n;

    logic             ready_q, valid_q;
    logic [XLEN-1:0]  main_imm, skid_imm, imm_c;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             main_err, skid_err, err_c;
    logic             in_fire, out_fire;
    logic             load_main, load_skid, pop_skid;

    // Replication count stays >= 1 for XLEN=32, so no zero-width concatenation.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN - 31){v[31]}}, v[30:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
        return {{(XLEN - 6){1'b0}}, v};
    endfunction

    always_comb begin
        imm_c = '0;
        err_c = 1'b0;
        case (in_extop)
            3'd0: imm_c = sext32({{20{in_instr[31]}}, in_instr[31:20]});
            3'd1: imm_c = sext32({in_instr[31:12], 12'b0});
            3'd2: imm_c = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            3'd3: imm_c = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0});
            3'd4: imm_c = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0});
            3'd5: imm_c = zext6({1'b0, in_instr[19:15]});
            3'd6: imm_c = (XLEN == 64) ? zext6(in_instr[25:20])
                                       : zext6({1'b0, in_instr[24:20]});
            default: err_c = 1'b1;
        endcase
    end

    assign in_fire  = in_valid & ready_q;
    assign out_fire = valid_q & out_ready;

    always_comb begin
        state_n   = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_n   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_n   = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_n  = ONE;
                    pop_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            main_imm <= '0;
            main_tag <= '0;
            main_err <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n != FULL);
            valid_q <= (state_n != EMPTY);
            if (load_main) begin
                main_imm <= imm_c;
                main_tag <= in_tag;
                main_err <= err_c;
            end else if (pop_skid) begin
                main_imm <= skid_imm;
                main_tag <= skid_tag;
                main_err <= skid_err;
            end
            if (load_skid) begin
                skid_imm <= imm_c;
                skid_tag <= in_tag;
                skid_err <= err_c;
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_imm   = main_imm;
    assign out_tag   = main_tag;
    assign out_err   = main_err;
    assign dbg_state = state;

endmodule
